// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared types and constants for the push-button conditioner.
//   btn_state_e  per-channel debounce FSM state (2-bit encoding)
//   BTN_L/R/U/D  channel index of each board button within btn_raw/btn_*
//   cnt_width()  counter width for a terminal count, never narrower than 1 bit
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_U = 2;
    localparam int unsigned BTN_D = 3;

    // Width needed to count 0..n-1; a single-cycle count still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- 2-flop synchroniser, debounce FSM,
// debounce counter and optional hold-to-repeat timer.
// Build option: define BTN_AUTOREPEAT_EN to include the repeat timer; otherwise
// btn_repeat is tied low and no repeat counter exists.
// Ports:
//   ClkPort     in   system clock
//   Reset       in   asynchronous, active-high reset
//   btn_raw     in   raw asynchronous button contact
//   btn_level   out  debounced state, 1 = pressed (registered)
//   btn_pulse   out  one-cycle pulse per accepted press (registered)
//   btn_repeat  out  one-cycle auto-repeat pulses while held (registered)
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    // Must satisfy 1 <= RPT_PERIOD <= RPT_DELAY.
    parameter int unsigned RPT_PERIOD = 20_000_000
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_repeat
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; bit 1 is the metastability-safe copy.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign sync = sync_q[1];

    // Debounce FSM. The counter only increments below CNT_LAST and is cleared on
    // every entry into a debounce state, so it can never wrap.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        btn_level <= 1'b1;
                        btn_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE: begin
                    // A release glitch returns to HELD silently.
                    if (sync) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_W = cnt_width(RPT_DELAY);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_DELAY - 1);
    // After each repeat, restart part-way so the next one is RPT_PERIOD away.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt;

    // The timer is held at 0 whenever the channel is not staying in HELD, so every
    // entry into HELD (from DB_PRESS or a release glitch) starts it from 0. Because
    // the entry edge itself never counts, btn_repeat cannot coincide with btn_pulse.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            rpt_cnt    <= '0;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            if (state == HELD && sync) begin
                if (rpt_cnt == RPT_LAST) begin
                    btn_repeat <= 1'b1;
                    rpt_cnt    <= RPT_RELOAD;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else begin
                rpt_cnt <= '0;
            end
        end
    end
`else
    assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button conditioner. Each raw button is
// synchronised, debounced and turned into a clean level, a one-cycle press pulse
// and (optionally) a hold-to-repeat pulse train. Channels are fully independent.
// Build option: define BTN_AUTOREPEAT_EN to enable auto-repeat; otherwise
// btn_repeat is constant 0.
// Ports:
//   ClkPort        in   100 MHz system clock
//   Reset          in   asynchronous, active-high reset
//   btn_raw        in   [N_BTN] raw buttons (bit 0 = L, 1 = R, 2 = U, 3 = D)
//   btn_level      out  [N_BTN] debounced state, 1 = pressed
//   btn_pulse      out  [N_BTN] one-cycle pulse per accepted press
//   btn_repeat     out  [N_BTN] one-cycle auto-repeat pulses while held
//   btn_any_pulse  out  OR of btn_pulse
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    parameter int unsigned RPT_PERIOD = 20_000_000
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             btn_any_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .ClkPort    (ClkPort),
            .Reset      (Reset),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_pulse  (btn_pulse[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

    // OR of registered pulses only; nothing here is combinational from btn_raw.
    assign btn_any_pulse = |btn_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed bench for button_conditioner with small timing
// parameters (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=5). Expected repeat activity
// follows whether BTN_AUTOREPEAT_EN is defined for the build.
module tb_button_conditioner;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned DB    = 4;
    localparam int unsigned RD    = 10;
    localparam int unsigned RP    = 5;
    localparam int          MAXC  = 64;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic             ClkPort = 1'b0;
    logic             Reset;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_repeat;
    logic             btn_any_pulse;

    int checks = 0;
    int errors = 0;

    // raw_seq[k] is sampled at edge k; cap_*[k] hold outputs just after edge k.
    logic [N_BTN-1:0] raw_seq   [MAXC];
    logic [N_BTN-1:0] cap_level [MAXC];
    logic [N_BTN-1:0] cap_pulse [MAXC];
    logic [N_BTN-1:0] cap_rpt   [MAXC];
    logic             cap_any   [MAXC];

    button_conditioner #(
        .N_BTN      (N_BTN),
        .DB_CYCLES  (DB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .ClkPort       (ClkPort),
        .Reset         (Reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .btn_pulse     (btn_pulse),
        .btn_repeat    (btn_repeat),
        .btn_any_pulse (btn_any_pulse)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [N_BTN-1:0] val);
        for (int k = lo; k < hi; k++) raw_seq[k] = val;
    endtask

    task automatic run_seq(input int n);
        for (int k = 0; k < n; k++) begin
            btn_raw = raw_seq[k];
            @(posedge ClkPort);
            #1;
            cap_level[k] = btn_level;
            cap_pulse[k] = btn_pulse;
            cap_rpt[k]   = btn_repeat;
            cap_any[k]   = btn_any_pulse;
        end
    endtask

    // sel: 0 = pulse, 1 = repeat, 2 = level, 3 = any_pulse (ch ignored)
    function automatic int count_hi(input int sel, input int ch, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            case (sel)
                0:       c += int'(cap_pulse[k][ch]);
                1:       c += int'(cap_rpt[k][ch]);
                2:       c += int'(cap_level[k][ch]);
                default: c += int'(cap_any[k]);
            endcase
        end
        return c;
    endfunction

    function automatic logic [N_BTN-1:0] or_all(input int n);
        logic [N_BTN-1:0] acc = '0;
        for (int k = 0; k < n; k++) acc |= cap_level[k] | cap_pulse[k] | cap_rpt[k];
        return acc;
    endfunction

    initial begin
        Reset   = 1'b1;
        btn_raw = '0;
        repeat (3) @(posedge ClkPort);
        #1;
        check_eq("rst_level", btn_level, 0);
        check_eq("rst_pulse", btn_pulse, 0);
        check_eq("rst_repeat", btn_repeat, 0);
        check_eq("rst_any", btn_any_pulse, 0);
        // Buttons pressed during reset must not leak through.
        btn_raw = 4'b1111;
        repeat (8) @(posedge ClkPort);
        #1;
        check_eq("rst_hold_level", btn_level, 0);
        btn_raw = '0;
        repeat (3) @(posedge ClkPort);
        #1;
        Reset = 1'b0;
        repeat (4) @(posedge ClkPort);
        #1;

        // 1. Clean press on L, then clean release.
        fill(0, 30, 4'b0001);
        run_seq(30);
        check_eq("t1_pulse_cnt", count_hi(0, 0, 30), 1);
        check_eq("t1_pulse_at6", cap_pulse[6], 4'b0001);
        check_eq("t1_pulse_at5", cap_pulse[5], 4'b0000);
        check_eq("t1_level_at5", cap_level[5], 4'b0000);
        check_eq("t1_level_at6", cap_level[6], 4'b0001);
        check_eq("t1_level_at29", cap_level[29], 4'b0001);
        check_eq("t1_level_days", count_hi(2, 0, 30), 24);
        check_eq("t1_any_at6", cap_any[6], 1);
        check_eq("t1_other_ch", or_all(30) & 4'b1110, 0);
        check_eq("t1_rpt_cnt", count_hi(1, 0, 30), AR ? 3 : 0);
        check_eq("t1_rpt_at16", cap_rpt[16][0], AR);
        fill(0, 12, 4'b0000);
        run_seq(12);
        check_eq("t1_rel_level5", cap_level[5][0], 1);
        check_eq("t1_rel_level6", cap_level[6][0], 0);

        // 2. Bounce on R, never stable for DB_CYCLES.
        fill(0, 2, 4'b0010);
        fill(2, 4, 4'b0000);
        fill(4, 6, 4'b0010);
        fill(6, 20, 4'b0000);
        run_seq(20);
        check_eq("t2_bounce_outs", or_all(20), 0);
        check_eq("t2_bounce_any", count_hi(3, 0, 20), 0);

        // 3. Two-cycle release glitch while L is held.
        fill(0, 10, 4'b0001);
        fill(10, 12, 4'b0000);
        fill(12, 26, 4'b0001);
        fill(26, 38, 4'b0000);
        run_seq(38);
        check_eq("t3_pulse_cnt", count_hi(0, 0, 38), 1);
        check_eq("t3_level_cycles", count_hi(2, 0, 38), 26);
        check_eq("t3_level_at13", cap_level[13][0], 1);
        check_eq("t3_level_at32", cap_level[32][0], 0);
        check_eq("t3_rpt_cnt", count_hi(1, 0, 38), AR ? 1 : 0);
        check_eq("t3_rpt_at24", cap_rpt[24][0], AR);

        // 4. Auto-repeat on U held for 40 cycles.
        fill(0, 40, 4'b0100);
        fill(40, 52, 4'b0000);
        run_seq(52);
        check_eq("t4_pulse_at6", cap_pulse[6], 4'b0100);
        check_eq("t4_pulse_cnt", count_hi(0, 2, 52), 1);
        check_eq("t4_rpt_cnt", count_hi(1, 2, 52), AR ? 6 : 0);
        for (int j = 0; j < 6; j++) begin
            check_eq($sformatf("t4_rpt_at%0d", 16 + 5 * j), cap_rpt[16 + 5 * j][2], AR);
        end
        check_eq("t4_rpt_at15", cap_rpt[15][2], 0);
        check_eq("t4_level_at46", cap_level[46][2], 0);

        // 5. Simultaneous press of L and R.
        fill(0, 10, 4'b0011);
        fill(10, 22, 4'b0000);
        run_seq(22);
        check_eq("t5_pulse_at6", cap_pulse[6], 4'b0011);
        check_eq("t5_any_at6", cap_any[6], 1);
        check_eq("t5_any_cnt", count_hi(3, 0, 22), 1);
        check_eq("t5_level_at6", cap_level[6], 4'b0011);

        // 6. Reset while L is held; L stays pressed through and after reset.
        fill(0, 10, 4'b0001);
        run_seq(10);
        check_eq("t6_held_level", cap_level[9], 4'b0001);
        #3;
        Reset = 1'b1;
        #1;
        check_eq("t6_rst_level", btn_level, 0);
        check_eq("t6_rst_pulse", btn_pulse, 0);
        check_eq("t6_rst_rpt", btn_repeat, 0);
        check_eq("t6_rst_any", btn_any_pulse, 0);
        repeat (2) @(posedge ClkPort);
        #1;
        Reset = 1'b0;
        fill(0, 12, 4'b0001);
        fill(12, 24, 4'b0000);
        run_seq(24);
        check_eq("t6_pulse_cnt", count_hi(0, 0, 24), 1);
        check_eq("t6_pulse_at6", cap_pulse[6][0], 1);
        check_eq("t6_level_at5", cap_level[5][0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
